// File: rtl/shift_deserializer_pkg.sv
// Shared types for the shift deserializer: output buffer state encoding
// and serial bit-order constants.
package shift_deserializer_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_core.sv
// Serial collection stage: shift register, bit counter and per-word direction latch.
// word/word_done describe the word that completes at the coming edge.
module shift_deser_core
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             dir,
    input  logic             frame_sync,
    output logic             word_done,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy
);

    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] bit_count_r;
    logic             busy_r;
    logic             dir_r;

    logic             accept_s;
    logic             first_bit_s;
    logic             last_bit_s;
    logic             dir_eff_s;
    logic [CNT_W-1:0] count_eff_s;
    logic [WIDTH-1:0] shreg_base_s;
    logic [WIDTH-1:0] shreg_next_s;

    // Frame sync realigns to bit 0 at this edge, so an accepted bit becomes bit 0.
    always_comb begin
        accept_s     = enable && sin_valid;
        count_eff_s  = frame_sync ? {CNT_W{1'b0}} : bit_count_r;
        shreg_base_s = frame_sync ? {WIDTH{1'b0}} : shreg_r;
        first_bit_s  = (count_eff_s == {CNT_W{1'b0}});
        last_bit_s   = (count_eff_s == CNT_W'(WIDTH - 1));
        dir_eff_s    = first_bit_s ? dir : dir_r;
        if (dir_eff_s == DIR_LSB_FIRST) begin
            shreg_next_s = {sin_data, shreg_base_s[WIDTH-1:1]};
        end else begin
            shreg_next_s = {shreg_base_s[WIDTH-2:0], sin_data};
        end
    end

    // Shift register, counter and direction latch state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg_r     <= {WIDTH{1'b0}};
            bit_count_r <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            dir_r       <= DIR_MSB_FIRST;
        end else if (accept_s) begin
            shreg_r     <= shreg_next_s;
            bit_count_r <= last_bit_s ? {CNT_W{1'b0}} : count_eff_s + CNT_W'(1);
            busy_r      <= !last_bit_s;
            if (first_bit_s) begin
                dir_r <= dir;
            end
        end else if (frame_sync) begin
            shreg_r     <= {WIDTH{1'b0}};
            bit_count_r <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
        end
    end

    assign word_done = accept_s && last_bit_s;
    assign word      = shreg_next_s;
    assign bit_count = bit_count_r;
    assign busy      = busy_r;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: collection core plus a one-entry
// valid/ready output buffer with sticky overrun reporting.
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             dir,
    input  logic             frame_sync,
    input  logic             out_ready,
    input  logic             clear_ovr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    buf_state_e       state_r;
    buf_state_e       state_next_s;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             overrun_r;
    logic             load_s;
    logic             ovr_set_s;
    logic             word_done_s;
    logic [WIDTH-1:0] word_s;

    shift_deser_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .dir        (dir),
        .frame_sync (frame_sync),
        .word_done  (word_done_s),
        .word       (word_s),
        .bit_count  (bit_count),
        .busy       (busy)
    );

    // Buffer next-state: a completion while full is dropped unless the consumer drains it.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        ovr_set_s    = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                if (word_done_s) begin
                    state_next_s = BUF_FULL;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (word_done_s && out_ready) begin
                    load_s = 1'b1;
                end else if (word_done_s) begin
                    ovr_set_s = 1'b1;
                end else if (out_ready) begin
                    state_next_s = BUF_EMPTY;
                end else begin
                    state_next_s = BUF_FULL;
                end
            end
            default: begin
                state_next_s = BUF_EMPTY;
            end
        endcase
    end

    // Buffer state, held word and sticky overrun (a new overrun beats clear_ovr).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= BUF_EMPTY;
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == BUF_FULL);
            if (load_s) begin
                out_data_r <= word_s;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clear_ovr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_shift_deserializer.sv
// Scenario-driven bench for shift_deserializer; expected words are queued
// as bits are sent and popped when the buffer presents them.
module tb_shift_deserializer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       sin_valid = 1'b0;
    logic       sin_data = 1'b0;
    logic       dir = 1'b0;
    logic       frame_sync = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_ovr = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       busy;
    logic [1:0] bit_count;
    logic       overrun;

    logic [3:0] exp_q[$];
    logic [3:0] exp_w;
    int         n_checks = 0;
    int         n_pass = 0;

    shift_deserializer #(.WIDTH(4), .CNT_W(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .dir        (dir),
        .frame_sync (frame_sync),
        .out_ready  (out_ready),
        .clear_ovr  (clear_ovr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic send_bit(input logic b, input logic fs);
        @(negedge clock);
        sin_valid  = 1'b1;
        sin_data   = b;
        frame_sync = fs;
        @(posedge clock);
        #1;
        sin_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic consume();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 4'b0000) $display("FAIL reset_out valid=%b data=%b required 0/0000", out_valid, out_data); else n_pass++;
        n_checks++; if (bit_count !== 2'd0 || busy !== 1'b0 || overrun !== 1'b0) $display("FAIL reset_state cnt=%0d busy=%b ovr=%b required 0/0/0", bit_count, busy, overrun); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_msb_first();
        exp_q.push_back(4'b1010);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        n_checks++; if (bit_count !== 2'd2 || busy !== 1'b1) $display("FAIL msb_partial cnt=%0d busy=%b required 2/1", bit_count, busy); else n_pass++;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        exp_w = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_w) $display("FAIL msb_word valid=%b data=%b required 1/%b", out_valid, out_data, exp_w); else n_pass++;
        n_checks++; if (bit_count !== 2'd0 || busy !== 1'b0) $display("FAIL msb_wrap cnt=%0d busy=%b required 0/0", bit_count, busy); else n_pass++;
        consume();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL msb_consume valid=%b required 0", out_valid); else n_pass++;
    endtask

    task automatic test_lsb_dir_toggle();
        exp_q.push_back(4'b1010);
        dir = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        dir = 1'b0;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        exp_w = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_w) $display("FAIL lsb_word valid=%b data=%b required 1/%b", out_valid, out_data, exp_w); else n_pass++;
        consume();
    endtask

    task automatic test_overrun();
        exp_q.push_back(4'b1100);
        send_word(4'b1100);
        send_word(4'b0011);
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set ovr=%b required 1", overrun); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) $display("FAIL ovr_hold valid=%b data=%b required 1/%b", out_valid, out_data, exp_q[0]); else n_pass++;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        clear_ovr = 1'b1;
        send_bit(1'b1, 1'b0);
        clear_ovr = 1'b0;
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_wins ovr=%b required 1", overrun); else n_pass++;
        @(negedge clock);
        clear_ovr = 1'b1;
        @(posedge clock);
        #1;
        clear_ovr = 1'b0;
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear ovr=%b required 0", overrun); else n_pass++;
        exp_w = exp_q.pop_front();
        n_checks++; if (out_data !== exp_w) $display("FAIL ovr_data data=%b required %b", out_data, exp_w); else n_pass++;
        consume();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ovr_consume valid=%b required 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(4'b1111);
        send_word(4'b1111);
        exp_w = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_w) $display("FAIL b2b_first valid=%b data=%b required 1/%b", out_valid, out_data, exp_w); else n_pass++;
        exp_q.push_back(4'b0110);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        out_ready = 1'b0;
        exp_w = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_w) $display("FAIL b2b_second valid=%b data=%b required 1/%b", out_valid, out_data, exp_w); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL b2b_ovr ovr=%b required 0", overrun); else n_pass++;
        consume();
    endtask

    task automatic test_frame_sync();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        n_checks++; if (bit_count !== 2'd1 || busy !== 1'b1) $display("FAIL sync_count cnt=%0d busy=%b required 1/1", bit_count, busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || overrun !== 1'b0) $display("FAIL sync_buffer valid=%b ovr=%b required 0/0", out_valid, overrun); else n_pass++;
        exp_q.push_back(4'b1001);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        exp_w = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_w) $display("FAIL sync_word valid=%b data=%b required 1/%b", out_valid, out_data, exp_w); else n_pass++;
        consume();
    endtask

    task automatic test_async_reset_enable();
        send_word(4'b0111);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 4'b0000) $display("FAIL areset_out valid=%b data=%b required 0/0000", out_valid, out_data); else n_pass++;
        n_checks++; if (bit_count !== 2'd0 || busy !== 1'b0 || overrun !== 1'b0) $display("FAIL areset_state cnt=%0d busy=%b ovr=%b required 0/0/0", bit_count, busy, overrun); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            sin_valid = i[0];
            sin_data  = 1'b1;
        end
        @(posedge clock);
        #1;
        sin_valid = 1'b0;
        n_checks++; if (bit_count !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL enable_freeze cnt=%0d busy=%b valid=%b required 2/1/0", bit_count, busy, out_valid); else n_pass++;
        enable = 1'b1;
        exp_q.push_back(4'b1011);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        exp_w = exp_q.pop_front();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_w) $display("FAIL enable_resume valid=%b data=%b required 1/%b", out_valid, out_data, exp_w); else n_pass++;
        consume();
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_dir_toggle();
        test_overrun();
        test_back_to_back();
        test_frame_sync();
        test_async_reset_enable();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_left size=%0d required 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
